// File: rtl/pgnt_arb_pkg.sv
// rtl/pgnt_arb_pkg.sv - shared state encoding and default sizing for the grant arbiter
package pgnt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_HOLD = 3;

endpackage

// File: rtl/pgnt_rr_pick.sv
// rtl/pgnt_rr_pick.sv - combinational round-robin winner selection
module pgnt_rr_pick
  import pgnt_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the last hit is the one right after last_winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IW'((int'(last_winner) + off) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pgnt_arbiter.sv
// rtl/pgnt_arbiter.sv - snapshot-based round-robin arbiter with fixed-length grants
module pgnt_arbiter
  import pgnt_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int HOLD = DEF_HOLD,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic            pclk,
  input  logic            prst,
  input  logic [NREQ-1:0] preq,
  output logic [NREQ-1:0] pgnt,
  output logic            pbusy,
  output logic [IW-1:0]   pgnt_id
);

  state_t          state;
  logic [NREQ-1:0] snap;
  logic [3:0]      hold_cnt;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   winner;
  logic            winner_ok;

  pgnt_rr_pick #(.NREQ(NREQ)) u_pick (
    .req         (snap),
    .last_winner (last_winner),
    .winner      (winner),
    .valid       (winner_ok)
  );

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state       <= IDLE;
      pgnt        <= '0;
      pbusy       <= 1'b0;
      pgnt_id     <= '0;
      snap        <= '0;
      hold_cnt    <= '0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|preq) begin
            snap  <= preq;
            pbusy <= 1'b1;
            state <= ARB;
          end
        end
        ARB: begin
          if (winner_ok) begin
            pgnt         <= '0;
            pgnt[winner] <= 1'b1;
            pgnt_id      <= winner;
            last_winner  <= winner;
            hold_cnt     <= 4'(HOLD - 1);
            state        <= GRANT;
          end else begin
            pbusy <= 1'b0;
            state <= IDLE;
          end
        end
        GRANT: begin
          if (hold_cnt == 4'd0) begin
            pgnt <= '0;
            // Pending requests go straight back to arbitration without an idle cycle.
            if (|preq) begin
              snap  <= preq;
              state <= ARB;
            end else begin
              pbusy <= 1'b0;
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: begin
          pgnt  <= '0;
          pbusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
